// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, default parameters and read-return payload for mem_responder
package mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_RD_LATENCY = 3;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic err;
  } rd_resp_t;
endpackage

// File: rtl/mem_resp_pipe.sv
// mem_resp_pipe: fixed-depth delay line for a valid bit plus payload
module mem_resp_pipe #(
  parameter int DEPTH = 3,
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  output logic [W-1:0] pop_data
);
  logic [DEPTH-1:0] v;
  logic [W-1:0] d [DEPTH];
  // advance every stage once per cycle; reset drops anything in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      v[0] <= push_valid;
      d[0] <= push_data;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  assign pop_valid = v[DEPTH-1];
  assign pop_data = d[DEPTH-1];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory model answering one read and one write per cycle
module mem_responder
  import mem_pkg::*;
#(
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_ret_address,
  output logic              wr_ret_ack,
  input  logic [ADDR_W-1:0] rd_address,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_ret_data,
  output logic [ADDR_W-1:0] rd_ret_address,
  output logic              rd_ret_ack,
  output logic              rd_ret_err
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic wr_ok, rd_ok, rd_valid;
  rd_resp_t rd_req, rd_resp;
  assign wr_ok = (wr_address >> IDX_W) == '0;
  assign rd_ok = (rd_address >> IDX_W) == '0;
  // commit in-range writes only; reset clears every word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    else if (wr_en && wr_ok)
      mem[wr_address[IDX_W-1:0]] <= wr_data;
  // acknowledge every sampled write in the following cycle, address zeroed when idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ret_ack <= 1'b0;
      wr_ret_address <= '0;
    end else begin
      wr_ret_ack <= wr_en;
      wr_ret_address <= wr_en ? wr_address : '0;
    end
  // snapshot memory before this edge's write lands; idle slots carry all zeros
  always_comb
    rd_req = rd_en ? rd_resp_t'{addr: rd_address, data: rd_ok ? mem[rd_address[IDX_W-1:0]] : '0, err: !rd_ok} : '0;
  mem_resp_pipe #(.DEPTH(RD_LATENCY), .W($bits(rd_resp_t))) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (rd_en),
    .push_data  (rd_req),
    .pop_valid  (rd_valid),
    .pop_data   (rd_resp)
  );
  assign rd_ret_ack = rd_valid;
  assign rd_ret_address = rd_resp.addr;
  assign rd_ret_data = rd_resp.data;
  assign rd_ret_err = rd_resp.err;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench driving a latency-3 and a latency-1 responder in lockstep
module tb_mem_responder;
  typedef struct { int due; logic [15:0] addr; logic [15:0] data; logic err; } rexp_t;
  typedef struct { int due; logic [15:0] addr; } wexp_t;
  logic clk = 0;
  logic rst_n = 1;
  logic [15:0] wr_address = 0, wr_data = 0, rd_address = 0;
  logic wr_en = 0, rd_en = 0;
  logic [15:0] rdat [2], radr [2], wadr [2];
  logic rack [2], rerr [2], wack [2];
  rexp_t rq [2][$];
  wexp_t wq [2][$];
  logic [15:0] model [256];
  int checks = 0, failures = 0, cyc = 0;
  always #5 clk = ~clk;
  mem_responder #(.RD_LATENCY(3), .MEM_DEPTH(256)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .wr_address(wr_address), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ret_address(wadr[0]), .wr_ret_ack(wack[0]),
    .rd_address(rd_address), .rd_en(rd_en),
    .rd_ret_data(rdat[0]), .rd_ret_address(radr[0]), .rd_ret_ack(rack[0]), .rd_ret_err(rerr[0])
  );
  mem_responder #(.RD_LATENCY(1), .MEM_DEPTH(256)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .wr_address(wr_address), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ret_address(wadr[1]), .wr_ret_ack(wack[1]),
    .rd_address(rd_address), .rd_en(rd_en),
    .rd_ret_data(rdat[1]), .rd_ret_address(radr[1]), .rd_ret_ack(rack[1]), .rd_ret_err(rerr[1])
  );
  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic monitor();
    rexp_t e;
    wexp_t w;
    for (int d = 0; d < 2; d++) begin
      if (rack[d]) begin
        if (rq[d].size() == 0) check($sformatf("rd_spurious%0d", d), 1, 0);
        else begin
          e = rq[d].pop_front();
          check($sformatf("rd_addr%0d", d), radr[d], e.addr);
          check($sformatf("rd_data%0d", d), rdat[d], e.data);
          check($sformatf("rd_err%0d", d), rerr[d], e.err);
          check($sformatf("rd_lat%0d", d), cyc, e.due);
        end
      end else begin
        check($sformatf("rd_idle_zero%0d", d), {radr[d], rdat[d], rerr[d]}, 0);
        if (rq[d].size() != 0 && rq[d][0].due <= cyc) begin
          check($sformatf("rd_missing%0d", d), 0, 1);
          void'(rq[d].pop_front());
        end
      end
      if (wack[d]) begin
        if (wq[d].size() == 0) check($sformatf("wr_spurious%0d", d), 1, 0);
        else begin
          w = wq[d].pop_front();
          check($sformatf("wr_addr%0d", d), wadr[d], w.addr);
          check($sformatf("wr_lat%0d", d), cyc, w.due);
        end
      end else begin
        check($sformatf("wr_idle_zero%0d", d), wadr[d], 0);
        if (wq[d].size() != 0 && wq[d][0].due <= cyc) begin
          check($sformatf("wr_missing%0d", d), 0, 1);
          void'(wq[d].pop_front());
        end
      end
    end
  endtask
  task automatic step(logic we, logic [15:0] wa, logic [15:0] wd, logic re, logic [15:0] ra);
    logic rin;
    @(negedge clk);
    cyc++;
    monitor();
    wr_en = we; wr_address = wa; wr_data = wd; rd_en = re; rd_address = ra;
    rin = ra[15:8] == 8'h00;
    if (re)
      for (int d = 0; d < 2; d++)
        rq[d].push_back('{cyc + (d == 0 ? 3 : 1), ra, rin ? model[ra[7:0]] : 16'h0000, !rin});
    if (we) begin
      for (int d = 0; d < 2; d++) wq[d].push_back('{cyc + 1, wa});
      if (wa[15:8] == 8'h00) model[wa[7:0]] = wd;
    end
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_outs_zero", {rack[0], rack[1], rerr[0], rerr[1], wack[0], wack[1],
                            rdat[0], rdat[1], radr[0], radr[1], wadr[0], wadr[1]}, 0);
    for (int d = 0; d < 2; d++) begin
      rq[d].delete();
      wq[d].delete();
    end
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
    repeat (3) step(0, 0, 0, 0, 0);
    rst_n = 1;
  endtask
  initial begin
    #1;
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 16'(i), 16'(i), 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 16'(i));
    repeat (5) step(0, 0, 0, 0, 0);
    step(1, 16'd5, 16'hBEEF, 1, 16'd5);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'd5);
    step(0, 0, 0, 1, 16'h0100);
    step(1, 16'h0100, 16'h1234, 0, 0);
    step(0, 0, 0, 1, 16'h0000);
    step(1, 16'hFFFF, 16'h5555, 1, 16'hFFFF);
    repeat (5) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31)),
           16'($urandom),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31)));
    repeat (5) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'(i + 2));
    #2;
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 16'(i));
    step(0, 0, 0, 1, 16'd5);
    repeat (6) step(0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++)
      check($sformatf("queues_drained%0d", d), rq[d].size() + wq[d].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
